// File: rtl/load_store_unit.sv
// Byte/half/word load-store engine: turns one controller request into one or two
// word-aligned memory beats. Optional macro LSU_MISALIGNED_SPLIT_EN enables split beats.

module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  off,
  input  logic [2:0]  nbytes,
  input  logic        beat1,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  wbyte
);
  int src;

  // src is the store-data byte that lands in this lane; beat1 carries the tail bytes.
  always_comb begin
    src   = beat1 ? (LANE + 4 - int'(off)) : (LANE - int'(off));
    be    = (src >= 0) && (src < int'(nbytes));
    wbyte = (src >= 0 && src < 4) ? wdata[{src[1:0], 3'b000} +: 8] : 8'h00;
  end
endmodule

module load_store_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int NUM_LANES = 4;
  localparam int CW        = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int TO_M1     = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  state_t   state, state_nxt;
  lsu_req_t req_q;
  logic [CW-1:0] cnt;
  logic [31:0]   rbuf0;

  logic in_illegal, in_cross, in_legal;
  logic beat_ack, timeout, sel_cross;

  logic [1:0]  sel_off;
  logic [2:0]  sel_nbytes;
  logic [31:0] sel_wdata;
  logic [NUM_LANES-1:0]      lane_be;
  logic [NUM_LANES-1:0][7:0] lane_wb;

  logic [63:0] raw;
  logic [31:0] sh, ld_val, rdata_nxt;

  // Request legality decoded straight from the start-cycle inputs.
  always_comb begin
    in_illegal = (funct3[1:0] == 2'b11) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
    in_cross   = ({1'b0, addr[1:0]} + size_bytes(funct3[1:0])) > 3'd4;
`ifdef LSU_MISALIGNED_SPLIT_EN
    in_legal   = !in_illegal;
`else
    in_legal   = !in_illegal && !in_cross;
`endif
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign sel_cross = ({1'b0, req_q.off} + size_bytes(req_q.funct3[1:0])) > 3'd4;
`else
  assign sel_cross = 1'b0;
`endif

  assign beat_ack = mem_req && mem_ack;
  assign timeout  = (ACK_TIMEOUT > 0) && mem_req && !mem_ack && (cnt == CW'(TO_M1));

  // In IDLE the lanes prepare beat 0 from live inputs; afterwards beat 1 from the latch.
  always_comb begin
    sel_off    = (state == IDLE) ? addr[1:0] : req_q.off;
    sel_nbytes = (state == IDLE) ? size_bytes(funct3[1:0]) : size_bytes(req_q.funct3[1:0]);
    sel_wdata  = (state == IDLE) ? wdata : req_q.wdata;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_lane #(.LANE(g)) u_lane (
      .off    (sel_off),
      .nbytes (sel_nbytes),
      .beat1  (state != IDLE),
      .wdata  (sel_wdata),
      .be     (lane_be[g]),
      .wbyte  (lane_wb[g])
    );
  end

  // Load assembly: bytes in address order, shifted down to bit 0, then extended.
  always_comb begin
    raw = (state == BEAT1) ? {mem_rdata, rbuf0} : {32'h0, mem_rdata};
    sh  = 32'(raw >> {req_q.off, 3'b000});
    case (req_q.funct3[1:0])
      2'b00:   ld_val = req_q.funct3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   ld_val = req_q.funct3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ld_val = sh;
    endcase
    rdata_nxt = req_q.is_store ? 32'h0 : ld_val;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = in_legal ? BEAT0 : RESP;
      BEAT0: begin
        if (beat_ack)     state_nxt = sel_cross ? BEAT1 : RESP;
        else if (timeout) state_nxt = RESP;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      BEAT1: if (beat_ack || timeout) state_nxt = RESP;
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '0;
      cnt       <= '0;
      rbuf0     <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          req_q.is_store <= is_store;
          req_q.funct3   <= funct3;
          req_q.off      <= addr[1:0];
          req_q.wdata    <= wdata;
          err            <= !in_legal;
          rdata          <= '0;
          cnt            <= '0;
          if (in_legal) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= lane_be;
            mem_wdata <= lane_wb;
          end
        end
        BEAT0, BEAT1: begin
          if (beat_ack) begin
            cnt   <= '0;
            rbuf0 <= mem_rdata;
            if (state_nxt == BEAT1) begin
              mem_addr  <= mem_addr + 32'd4;
              mem_be    <= lane_be;
              mem_wdata <= lane_wb;
            end else begin
              mem_req <= 1'b0;
              rdata   <= rdata_nxt;
            end
          end else if (timeout) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
          end else if (mem_req) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (ACK_TIMEOUT=4).
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst, start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int passed = 0;
  int total  = 0;

  load_store_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Presents a request for one edge (E0); returns just after E0.
  task automatic go(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_be", 32'(mem_be), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    tick();

    // LB 0x103, acked in first request cycle
    go(1'b0, 3'b000, 32'h0000_0103, 32'h0);
    chk("lb_req", 32'(mem_req), 32'd1);
    chk("lb_addr", mem_addr, 32'h0000_0100);
    chk("lb_be", 32'(mem_be), 32'b1000);
    chk("lb_we", 32'(mem_we), 32'd0);
    chk("lb_busy", 32'(busy), 32'd1);
    chk("lb_nodone", 32'(done), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_FF00;
    tick();
    mem_ack = 1'b0;
    chk("lb_done", 32'(done), 32'd1);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_err", 32'(err), 32'd0);
    chk("lb_req_drop", 32'(mem_req), 32'd0);
    tick();
    chk("lb_idle_done", 32'(done), 32'd0);
    chk("lb_idle_busy", 32'(busy), 32'd0);
    chk("lb_rdata_held", rdata, 32'hFFFF_FF80);

    // LBU same address
    go(1'b0, 3'b100, 32'h0000_0103, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_FF00;
    tick();
    mem_ack = 1'b0;
    chk("lbu_done", 32'(done), 32'd1);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    tick();

    // SH 0x202 with three wait cycles; a stray start mid-beat is ignored
    go(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
    chk("sh_we", 32'(mem_we), 32'd1);
    chk("sh_addr", mem_addr, 32'h0000_0200);
    chk("sh_be", 32'(mem_be), 32'b1100);
    chk("sh_wdata", mem_wdata, 32'hABCD_0000);
    start = 1'b1; addr = 32'h0000_0999;
    tick();
    start = 1'b0;
    chk("sh_wait1_req", 32'(mem_req), 32'd1);
    chk("sh_ignore_start", mem_addr, 32'h0000_0200);
    tick();
    chk("sh_wait2_done", 32'(done), 32'd0);
    tick();
    chk("sh_wait3_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sh_done", 32'(done), 32'd1);
    chk("sh_err", 32'(err), 32'd0);
    chk("sh_rdata", rdata, 32'h0);
    tick();

    // LH 0x301: non-crossing misaligned half
    go(1'b0, 3'b001, 32'h0000_0301, 32'h0);
    chk("lh_be", 32'(mem_be), 32'b0110);
    mem_ack = 1'b1; mem_rdata = 32'h0080_0100;
    tick();
    mem_ack = 1'b0;
    chk("lh_done", 32'(done), 32'd1);
    chk("lh_rdata", rdata, 32'hFFFF_8001);
    tick();

    // LW 0x0FFF_FFFD crosses a word
    go(1'b0, 3'b010, 32'h0FFF_FFFD, 32'h0);
`ifdef LSU_MISALIGNED_SPLIT_EN
    chk("lw_b0_addr", mem_addr, 32'h0FFF_FFFC);
    chk("lw_b0_be", 32'(mem_be), 32'b1110);
    mem_ack = 1'b1; mem_rdata = 32'hAABB_CCDD;
    tick();
    chk("lw_b1_req", 32'(mem_req), 32'd1);
    chk("lw_b1_addr", mem_addr, 32'h1000_0000);
    chk("lw_b1_be", 32'(mem_be), 32'b0001);
    chk("lw_b1_nodone", 32'(done), 32'd0);
    mem_rdata = 32'h1122_3344;
    tick();
    mem_ack = 1'b0;
    chk("lw_done", 32'(done), 32'd1);
    chk("lw_rdata", rdata, 32'h44AA_BBCC);
    chk("lw_err", 32'(err), 32'd0);
`else
    chk("lw_done", 32'(done), 32'd1);
    chk("lw_err", 32'(err), 32'd1);
    chk("lw_noreq", 32'(mem_req), 32'd0);
    chk("lw_rdata", rdata, 32'h0);
`endif
    tick();

    // Illegal funct3 codes
    go(1'b0, 3'b011, 32'h0000_0040, 32'h0);
    chk("f011_done", 32'(done), 32'd1);
    chk("f011_err", 32'(err), 32'd1);
    chk("f011_noreq", 32'(mem_req), 32'd0);
    tick();
    go(1'b1, 3'b100, 32'h0000_0040, 32'h0000_00FF);
    chk("sb100_done", 32'(done), 32'd1);
    chk("sb100_err", 32'(err), 32'd1);
    chk("sb100_noreq", 32'(mem_req), 32'd0);
    tick();

    // Timeout: mem_req high for exactly 4 cycles then error
    go(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    chk("to_req0", 32'(mem_req), 32'd1);
    tick();
    chk("to_req1", 32'(mem_req), 32'd1);
    tick();
    chk("to_req2", 32'(mem_req), 32'd1);
    tick();
    chk("to_req3", 32'(mem_req), 32'd1);
    chk("to_nodone", 32'(done), 32'd0);
    tick();
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("to_done", 32'(done), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rdata", rdata, 32'h0);
    tick();

    // Reset mid-beat aborts silently, then a new start is accepted
    go(1'b0, 3'b010, 32'h0000_0080, 32'h0);
    chk("rm_req", 32'(mem_req), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_req_drop", 32'(mem_req), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_nodone", 32'(done), 32'd0);
    tick();
    chk("rm_nodone2", 32'(done), 32'd0);
    go(1'b0, 3'b100, 32'h0000_0101, 32'h0);
    chk("rm_new_be", 32'(mem_be), 32'b0010);
    mem_ack = 1'b1; mem_rdata = 32'h0000_5A00;
    tick();
    mem_ack = 1'b0;
    chk("rm_new_done", 32'(done), 32'd1);
    chk("rm_new_rdata", rdata, 32'h0000_005A);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte/half/word load-store engine sitting directly downstream of the multicycle controller's memory-address step and upstream of the word-wide data memory. On a start pulse it converts an ALU-computed byte address, funct3 size/sign code and store data into one or two word-aligned memory beats with byte enables. It also sign/zero-extends load data for register write-back and reports illegal or timed-out accesses.

## Interface
- ACK_TIMEOUT, 255: maximum cycles a beat may wait for mem_ack before the access aborts with error. 0 disables the timeout.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request from controller; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load; sampled with start
- funct3  in  3  RV32I size code: [1:0] 00 byte, 01 half, 10 word; [2] unsigned (loads only); sampled with start
- addr  in  32  byte address; sampled with start
- wdata  in  32  store data, right-aligned (rs2); sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result; valid while done=1, held until next start
- err  out  1  valid while done=1: illegal funct3, unsupported misalignment, or timeout
- mem_req  out  1  beat request, held until acknowledged
- mem_we  out  1  1 = write beat
- mem_addr  out  32  word-aligned address ([1:0]=00)
- mem_be  out  4  byte enables, bit n = byte lane n (little-endian)
- mem_wdata  out  32  store data shifted into lanes
- mem_ack  in  1  beat completes in any cycle where mem_req && mem_ack
- mem_rdata  in  32  read data, valid with mem_ack on read beats

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - start=1 latches the inputs.
  - Legal access -> BEAT0.
  - Illegal access -> RESP with err=1 and no memory traffic.
  - start while not IDLE is ignored.
- Illegal funct3 codes:
  - Any: 011, 11x.
  - Stores only: 1xx.
- Access span: off=addr[1:0], size = 1/2/4 bytes. It crosses a word when off+size>4 (half at off 3; word at off 1..3).
- Non-crossing access:
  - Single beat in BEAT0: mem_addr={addr[31:2],2'b00}, mem_be=size mask<<off, mem_wdata=wdata<<(8*off).
  - BEAT0 -> RESP on ack.
- Crossing access (see Configuration):
  - BEAT0 carries the lanes off..3.
  - BEAT1 at mem_addr+4 carries the remaining low lanes. Address wraps 0xFFFFFFFC -> 0x00000000.
  - BEAT0 -> BEAT1 on ack; BEAT1 -> RESP on ack.
- Load assembly:
  - Bytes are collected in address order, then shifted to bit 0.
  - funct3[2]=0 sign-extends from bit 7/15; funct3[2]=1 zero-extends.
  - A word load is passed through unchanged.
- RESP: done=1 for exactly one cycle, then -> IDLE. rdata=0 on any err and on stores.
- Timeout:
  - A per-beat counter clears on entering BEAT0/BEAT1 and increments each cycle with mem_req && !mem_ack.
  - When it reaches ACK_TIMEOUT, mem_req drops next edge -> RESP with err=1.
- rst=1 at any edge (including mid-beat): state IDLE, counter 0, mem_req drops at that edge, no done pulse for the aborted access.

## Timing
- Reset values: busy 0, done 0, rdata 0, err 0, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0.
- Start sampled at edge E0. mem_req and all mem_* outputs are registered, driven from E0+1, and held stable until the ack edge.
- An ack in the first request cycle is legal. Minimum start-to-done is 2 cycles for a single beat and 3 cycles for a split access.
- Each extra wait cycle adds 1.
- mem_req deasserts in the cycle after the final ack. It is never high in RESP or IDLE.
- An illegal access pulses done at E0+1 with mem_req never asserted.
- busy=1 in BEAT0, BEAT1 and RESP; done and busy are both high in RESP.

## Configuration
- LSU_MISALIGNED_SPLIT_EN defined: crossing accesses are split into two beats as above.
- LSU_MISALIGNED_SPLIT_EN undefined:
  - BEAT1 is removed.
  - A crossing access is illegal: done with err=1 at E0+1, no memory traffic.
  - Non-crossing misaligned halves (off 1) remain supported.

## Test plan
- LB, addr 0x103, mem_rdata 0x80FF_FF00 acked first cycle -> mem_addr 0x100, be 1000, done at E0+2, rdata 0xFFFF_FF80, err 0; LBU same -> rdata 0x0000_0080.
- SH, addr 0x202, wdata 0x1234_ABCD, ack after 3 waits -> mem_we 1, be 1100, mem_wdata 0xABCD_0000, done at E0+5.
- LW, addr 0x0FFF_FFFD, split enabled, beat0 rdata 0xAABB_CCDD, beat1 rdata 0x1122_3344:
  - Beat addresses 0x0FFF_FFFC (be 1110) then 0x1000_0000 (be 0001).
  - rdata 0x44AA_BBCC.
- Same LW with the macro undefined -> no mem_req, done at E0+1, err 1, rdata 0.
- funct3=3'b011 load, and SB with funct3=3'b100 -> err 1 at E0+1, no memory traffic.
- ACK_TIMEOUT=4, mem_ack held 0 -> mem_req high for 4 cycles, done with err 1. A repeat run with rst pulsed mid-beat -> mem_req low next edge, no done, idle accepts a new start.
